// File: rtl/sdc_pkg.sv
// Shared constants, state encoding and CRC7 step for the SD card SPI responder.
package sdc_pkg;
    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC_ERR = 3;

    localparam logic [31:0] OCR_READY = 32'hC0FF_8000;
    localparam logic [31:0] OCR_BUSY  = 32'h00FF_8000;

    typedef enum logic [1:0] {S_HUNT, S_RX, S_DECODE, S_TX} state_t;

    // One bit of CRC7, polynomial x^7 + x^3 + 1, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction
endpackage

// File: rtl/sdc_crc7.sv
// Serial CRC7 accumulator; clr restarts the sum, and a simultaneous en feeds the first bit.
module sdc_crc7
    import sdc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   crc <= '0;
        else if (en)  crc <= crc7_step(clr ? 7'h00 : crc, din);
        else if (clr) crc <= '0;
    end
endmodule

// File: rtl/sdc_spi_responder.sv
// SPI-mode SD card model: oversamples SCK/CS/MOSI, frames 48-bit commands and answers R1/R3/R7.
module sdc_spi_responder
    import sdc_pkg::*;
#(
    parameter int NCR_BYTES   = 1,
    parameter int ACMD41_BUSY = 2,
    parameter int CRC_CHECK   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sck,
    input  logic        i_cs,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_ready,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd_idx,
    output logic [31:0] o_arg
);
    localparam int TX_BITS = 8 * (NCR_BYTES + 5);
    localparam int TXC_W   = $clog2(TX_BITS + 1);
    localparam logic [3:0] BUSY_LIM = 4'(ACMD41_BUSY);

    logic [1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_d;
    logic       sck_rise, sck_fall, cs, mosi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '1;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], i_sck};
            cs_sync   <= {cs_sync[0], i_cs};
            mosi_sync <= {mosi_sync[0], i_mosi};
            sck_d     <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;
    assign cs       = cs_sync[1];
    assign mosi     = mosi_sync[1];

    state_t             state, state_nxt;
    logic [44:0]        frame;      // command bits 45..1; start and end bits are not kept
    logic [5:0]         bit_cnt;
    logic [TX_BITS-1:0] tx_sh, tx_load;
    logic [TXC_W-1:0]   tx_cnt;
    logic               in_idle, app;
    logic [3:0]         busy_cnt;
    logic [6:0]         crc;
    logic               crc_clr, crc_en;

    assign crc_clr = (state == S_HUNT);
    assign crc_en  = sck_rise && ((state == S_HUNT && !mosi) || (state == S_RX && bit_cnt < 6'd40));

    sdc_crc7 u_crc7 (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (mosi),
        .crc   (crc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_HUNT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT:   if (sck_rise && !mosi) state_nxt = S_RX;
            S_RX:     if (sck_rise) begin
                          if (bit_cnt == 6'd1 && !mosi) state_nxt = S_HUNT;
                          else if (bit_cnt == 6'd47)    state_nxt = mosi ? S_DECODE : S_HUNT;
                      end
            S_DECODE: state_nxt = S_TX;
            S_TX:     if (sck_fall && tx_cnt == '0) state_nxt = S_HUNT;
            default:  state_nxt = S_HUNT;
        endcase
        if (cs) state_nxt = S_HUNT;
    end

    logic [5:0]  idx;
    logic [31:0] arg, ext;
    logic        crc_bad, illegal, long_rsp, idle_nxt, app_nxt;
    logic [3:0]  busy_nxt;
    logic [7:0]  r1;
    logic [39:0] rsp;

    // Response and next card state; only committed in DECODE.
    always_comb begin
        idx      = frame[44:39];
        arg      = frame[38:7];
        crc_bad  = (CRC_CHECK != 0) && (idx == CMD0 || idx == CMD8) && (frame[6:0] != crc);
        idle_nxt = in_idle;
        busy_nxt = busy_cnt;
        app_nxt  = 1'b0;
        illegal  = 1'b0;
        long_rsp = 1'b0;
        ext      = 32'h0;
        if (!crc_bad) begin
            case (idx)
                CMD0:  begin idle_nxt = 1'b1; busy_nxt = 4'd0; end
                CMD8:  begin long_rsp = 1'b1; ext = {20'h0, arg[11:0]}; end
                CMD55: app_nxt = 1'b1;
                CMD41: begin
                    if (!app)                  illegal  = 1'b1;
                    else if (busy_cnt < BUSY_LIM) busy_nxt = busy_cnt + 4'd1;
                    else                       idle_nxt = 1'b0;
                end
                CMD58: begin long_rsp = 1'b1; ext = in_idle ? OCR_BUSY : OCR_READY; end
                default: illegal = 1'b1;
            endcase
        end
        r1             = 8'h00;
        r1[R1_IDLE]    = idle_nxt;
        r1[R1_ILLEGAL] = illegal;
        r1[R1_CRC_ERR] = crc_bad;
        rsp            = long_rsp ? {r1, ext} : {r1, 32'h0};
        // Filler bytes of 0xFF in front, response left-aligned behind them.
        tx_load = ({rsp, {(TX_BITS-40){1'b0}}} >> (8*NCR_BYTES)) | ~({TX_BITS{1'b1}} >> (8*NCR_BYTES));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame       <= '0;
            bit_cnt     <= '0;
            tx_sh       <= '1;
            tx_cnt      <= '0;
            in_idle     <= 1'b1;
            app         <= 1'b0;
            busy_cnt    <= '0;
            o_miso      <= 1'b1;
            o_ready     <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_cmd_idx   <= '0;
            o_arg       <= '0;
        end else begin
            o_cmd_valid <= 1'b0;
            case (state)
                S_HUNT: if (sck_rise) begin
                    frame   <= '0;
                    bit_cnt <= 6'd1;
                end
                S_RX: if (sck_rise) begin
                    if (bit_cnt != 6'd47) frame <= {frame[43:0], mosi};
                    bit_cnt <= bit_cnt + 6'd1;
                end
                S_DECODE: if (!cs) begin
                    o_cmd_valid <= 1'b1;
                    o_cmd_idx   <= idx;
                    o_arg       <= arg;
                    in_idle     <= idle_nxt;
                    app         <= app_nxt;
                    busy_cnt    <= busy_nxt;
                    o_ready     <= ~idle_nxt;
                    tx_sh       <= tx_load;
                    tx_cnt      <= long_rsp ? TXC_W'(TX_BITS) : TXC_W'(8*NCR_BYTES + 8);
                end
                S_TX: if (sck_fall && tx_cnt != '0) begin
                    o_miso <= tx_sh[TX_BITS-1];
                    tx_sh  <= tx_sh << 1;
                    tx_cnt <= tx_cnt - 1'b1;
                end
                default: ;
            endcase
            if (cs || state_nxt != S_TX) o_miso <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdc_spi_responder.sv
// Directed bench: a host task drives SPI frames, monitors score MISO bytes and o_cmd_valid against queues.
module tb_sdc_spi_responder;
    localparam int NCR = 1;

    logic        clk = 1'b0, rst_n = 1'b0, sck = 1'b0, cs = 1'b1, mosi = 1'b1;
    logic        miso, ready, cmd_valid;
    logic [5:0]  cmd_idx;
    logic [31:0] arg;

    int checks = 0, failures = 0;
    logic [7:0]  rsp_q[$];
    logic [37:0] cmd_q[$];
    logic        rsp_win = 1'b0;

    always #5 clk = ~clk;

    sdc_spi_responder #(.NCR_BYTES(NCR), .ACMD41_BUSY(2), .CRC_CHECK(1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sck       (sck),
        .i_cs        (cs),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_ready     (ready),
        .o_cmd_valid (cmd_valid),
        .o_cmd_idx   (cmd_idx),
        .o_arg       (arg)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Response monitor: assembles MISO bytes on host SCK rises inside the response window.
    logic [7:0] rx_byte = 8'h00;
    int         rx_bits = 0;
    always @(posedge sck) begin
        if (!rsp_win) rx_bits = 0;
        else begin
            rx_byte = {rx_byte[6:0], miso};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_bits = 0;
                if (rsp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp_unexpected actual=%0h required=none", rx_byte);
                end else check("rsp_byte", 64'(rx_byte), 64'(rsp_q.pop_front()));
            end
        end
    end

    // Command monitor: every o_cmd_valid pulse must match the next queued frame.
    always @(negedge clk) begin
        if (cmd_valid) begin
            if (cmd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL cmd_unexpected actual=%0d/%h required=none", cmd_idx, arg);
            end else check("cmd_frame", 64'({cmd_idx, arg}), 64'(cmd_q.pop_front()));
        end
    end

    task automatic spi_bit(input logic b);
        mosi = b;
        #60 sck = 1'b1;
        #60 sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 5; i >= 0; i--) spi_byte(f[8*i +: 8]);
    endtask

    // Full transaction: frame out, NCR filler plus nrsp response bytes clocked back.
    task automatic send_cmd(input logic [47:0] f, input int nrsp, input logic [39:0] rsp);
        cmd_q.push_back({f[45:40], f[39:8]});
        for (int i = 0; i < NCR; i++) rsp_q.push_back(8'hFF);
        for (int i = 0; i < nrsp; i++) rsp_q.push_back(rsp[39-8*i -: 8]);
        send_frame(f);
        rsp_win = 1'b1;
        for (int i = 0; i < NCR + nrsp; i++) spi_byte(8'hFF);
        rsp_win = 1'b0;
        spi_byte(8'hFF);
    endtask

    task automatic cs_cycle();
        cs = 1'b1;
        repeat (6) @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int miso_low;
        repeat (3) @(negedge clk);
        check("rst_miso", 64'(miso), 64'd1);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_idx", 64'(cmd_idx), 64'd0);
        check("rst_arg", 64'(arg), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Dummy clocks and a full CMD0 pattern with CS high must be ignored.
        miso_low = 0;
        for (int i = 0; i < 80; i++) begin
            mosi = 1'b1;
            #60 sck = 1'b1;
            if (miso !== 1'b1) miso_low++;
            #60 sck = 1'b0;
        end
        send_frame(48'h40_00000000_95);
        check("cs_high_miso_low_count", 64'(miso_low), 64'd0);
        check("cs_high_miso", 64'(miso), 64'd1);
        cs = 1'b0;
        repeat (6) @(negedge clk);

        // CRC byte 0x01 keeps the end bit set while carrying a zero CRC7.
        send_cmd(48'h40_00000000_01, 1, {8'h09, 32'h0});
        send_cmd(48'h40_00000000_95, 1, {8'h01, 32'h0});
        send_cmd(48'h48_000001AA_87, 5, 40'h01_0000_01AA);
        send_cmd(48'h69_40000000_01, 1, {8'h05, 32'h0});
        send_cmd(48'h51_00000000_01, 1, {8'h05, 32'h0});
        send_cmd(48'h7A_00000000_01, 5, 40'h01_00FF_8000);
        check("ready_still_idle", 64'(ready), 64'd0);

        // Abort CMD0 after 20 bits, then a full CMD0 gives exactly one response.
        spi_byte(8'h40);
        spi_byte(8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        cs_cycle();
        send_cmd(48'h40_00000000_95, 1, {8'h01, 32'h0});

        // Abort inside the R7 payload while MISO is driving a 0.
        cmd_q.push_back({6'd8, 32'h000001AA});
        rsp_q.push_back(8'hFF);
        rsp_q.push_back(8'h01);
        send_frame(48'h48_000001AA_87);
        rsp_win = 1'b1;
        spi_byte(8'hFF);
        spi_byte(8'hFF);
        rsp_win = 1'b0;
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        #60;
        check("r7_mid_bit", 64'(miso), 64'd0);
        @(negedge clk);
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("cs_abort_miso", 64'(miso), 64'd1);
        repeat (6) @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        send_cmd(48'h48_000001AA_87, 5, 40'h01_0000_01AA);

        // Init loop: two busy ACMD41 replies, then ready.
        for (int k = 0; k < 3; k++) begin
            send_cmd(48'h77_00000000_01, 1, {8'h01, 32'h0});
            send_cmd(48'h69_40000000_01, 1, {(k < 2) ? 8'h01 : 8'h00, 32'h0});
            check("ready_after_acmd41", 64'(ready), (k == 2) ? 64'd1 : 64'd0);
        end
        send_cmd(48'h7A_00000000_01, 5, 40'h00_C0FF_8000);
        send_cmd(48'h77_00000000_01, 1, {8'h00, 32'h0});
        send_cmd(48'h40_00000000_95, 1, {8'h01, 32'h0});
        check("ready_after_cmd0", 64'(ready), 64'd0);

        cs = 1'b1;
        repeat (20) @(negedge clk);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
